// File: rtl/seg_pkg.sv
// Shared seven-segment constants (active-low, dp in bit 7) and scan state encodings.
package seg_pkg;

  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h90;
  localparam logic [7:0] SEG_A = 8'h88;
  localparam logic [7:0] SEG_B = 8'h83;
  localparam logic [7:0] SEG_C = 8'hC6;
  localparam logic [7:0] SEG_D = 8'hA1;
  localparam logic [7:0] SEG_E = 8'h86;
  localparam logic [7:0] SEG_F = 8'h8E;
  localparam logic [7:0] SEG_OFF = 8'hFF;

  localparam logic [5:0] SEL_NONE = 6'h3F;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_t;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Producer-side load handshake for the scan controller: display data, decimal points, load/ack.
interface seg_scan_ctrl_if;
  logic [23:0] data;
  logic [5:0]  point;
  logic        load;
  logic        load_ack;

  modport master (output data, output point, output load, input load_ack);
  modport slave  (input data, input point, input load, output load_ack);
endinterface

// File: rtl/seg_decode.sv
// Combinational hex nibble to active-low segment code (bits 6..0 = g..a), dp excluded.
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF[6:0];
    case (nib)
      4'h0: seg = SEG_0[6:0];
      4'h1: seg = SEG_1[6:0];
      4'h2: seg = SEG_2[6:0];
      4'h3: seg = SEG_3[6:0];
      4'h4: seg = SEG_4[6:0];
      4'h5: seg = SEG_5[6:0];
      4'h6: seg = SEG_6[6:0];
      4'h7: seg = SEG_7[6:0];
      4'h8: seg = SEG_8[6:0];
      4'h9: seg = SEG_9[6:0];
      4'hA: seg = SEG_A[6:0];
      4'hB: seg = SEG_B[6:0];
      4'hC: seg = SEG_C[6:0];
      4'hD: seg = SEG_D[6:0];
      4'hE: seg = SEG_E[6:0];
      4'hF: seg = SEG_F[6:0];
      default: seg = SEG_OFF[6:0];
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Six-digit multiplexed seven-segment scanner with blanking gaps and frame-aligned shadow loads.
// Define SEG_SCAN_LZ_BLANK_EN to blank leading-zero digits 5..1.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  seg_scan_ctrl_if.slave ld,
  output logic           frame_done,
  output logic [5:0]     sel,
  output logic [7:0]     seg_led
);

  localparam int CNT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] SHOW_LD  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LD = (BLANK_CYC > 0) ? CW'(BLANK_CYC - 1) : '0;
  localparam bit NO_BLANK = (BLANK_CYC == 0);

  scan_state_t   st;
  logic [2:0]    idx;
  logic [CW-1:0] cnt;
  logic [23:0]   data_sh;
  logic [5:0]    point_sh;
  logic          pend;
  logic          load_ack_q;

  logic          last_cyc;
  logic          frame_end;
  logic          new_req;
  logic          capture;

  logic [3:0]    nib_p0;
  logic          dp_p0;
  logic          lz_p0;
  logic [6:0]    seg7_p0;
  logic [5:0]    sel_p0;
  logic [7:0]    seg_p0;

  assign last_cyc  = (cnt == '0);
  assign frame_end = en && (st == SHOW) && (idx == 3'd5) && last_cyc;
  // A load still high during the ack cycle belongs to the request just served.
  assign new_req   = ld.load && !load_ack_q;
  assign capture   = (frame_end && (pend || new_req)) || ((st == OFF) && pend);
  assign ld.load_ack = load_ack_q;

  // Stage p0: select the current digit from the shadow registers and decode it
  always_comb begin
    nib_p0 = 4'h0;
    dp_p0  = 1'b0;
    lz_p0  = 1'b0;
    case (idx)
      3'd0: begin nib_p0 = data_sh[3:0];   dp_p0 = point_sh[0]; end
      3'd1: begin nib_p0 = data_sh[7:4];   dp_p0 = point_sh[1]; end
      3'd2: begin nib_p0 = data_sh[11:8];  dp_p0 = point_sh[2]; end
      3'd3: begin nib_p0 = data_sh[15:12]; dp_p0 = point_sh[3]; end
      3'd4: begin nib_p0 = data_sh[19:16]; dp_p0 = point_sh[4]; end
      3'd5: begin nib_p0 = data_sh[23:20]; dp_p0 = point_sh[5]; end
      default: ;
    endcase
`ifdef SEG_SCAN_LZ_BLANK_EN
    case (idx)
      3'd1: lz_p0 = (data_sh[23:4]  == '0);
      3'd2: lz_p0 = (data_sh[23:8]  == '0);
      3'd3: lz_p0 = (data_sh[23:12] == '0);
      3'd4: lz_p0 = (data_sh[23:16] == '0);
      3'd5: lz_p0 = (data_sh[23:20] == '0);
      default: lz_p0 = 1'b0;
    endcase
`endif
  end

  seg_decode u_dec (
    .nib (nib_p0),
    .seg (seg7_p0)
  );

  // en gates the drive directly so dropping it blanks on the very next edge.
  always_comb begin
    sel_p0 = SEL_NONE;
    seg_p0 = SEG_OFF;
    if (en && (st == SHOW)) begin
      sel_p0 = ~(6'b00_0001 << idx);
      seg_p0 = {~dp_p0, lz_p0 ? 7'h7F : seg7_p0};
    end
  end

  // Stage p1: scan FSM, shadow capture and registered pin drive
  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= OFF;
      idx        <= '0;
      cnt        <= '0;
      data_sh    <= '0;
      point_sh   <= '0;
      pend       <= 1'b0;
      load_ack_q <= 1'b0;
      frame_done <= 1'b0;
      sel        <= SEL_NONE;
      seg_led    <= SEG_OFF;
    end else begin
      frame_done <= 1'b0;
      load_ack_q <= capture;
      pend       <= (pend || new_req) && !capture;
      sel        <= sel_p0;
      seg_led    <= seg_p0;
      if (capture) begin
        data_sh  <= ld.data;
        point_sh <= ld.point;
      end
      if (!en) begin
        st  <= OFF;
        idx <= '0;
        cnt <= '0;
      end else begin
        case (st)
          OFF: begin
            idx <= '0;
            if (NO_BLANK) begin
              st  <= SHOW;
              cnt <= SHOW_LD;
            end else begin
              st  <= BLANK;
              cnt <= BLANK_LD;
            end
          end
          BLANK: begin
            if (last_cyc) begin
              st  <= SHOW;
              cnt <= SHOW_LD;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          SHOW: begin
            if (last_cyc) begin
              idx        <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
              frame_done <= (idx == 3'd5);
              if (NO_BLANK) begin
                st  <= SHOW;
                cnt <= SHOW_LD;
              end else begin
                st  <= BLANK;
                cnt <= BLANK_LD;
              end
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          default: begin
            st  <= OFF;
            idx <= '0;
            cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule
